regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the RV32 core: NRD registered read

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_mp_rd.sv | 61 ++++++
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and data/address types for the
// multi-port integer register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   rf_addr_t;
  typedef logic [XLEN_DEF-1:0] rf_data_t;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_rd.sv
// One registered read port: zero-register check, write-conflict resolution,
// optional same-cycle write bypass and busy-flag selection.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int AW     = rf_aw(NREGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AW-1:0]              i_addr,
  input  logic [NREGS-1:0][XLEN-1:0] i_regs,
  input  logic [NREGS-1:0]           i_busy_cur,
  input  logic [NREGS-1:0]           i_busy_next,
  input  logic [NWR-1:0]             i_wr_en,
  input  logic [NWR*AW-1:0]          i_wr_addr,
  input  logic [NWR*XLEN-1:0]        i_wr_data,
  output logic [XLEN-1:0]            o_data,
  output logic                       o_busy
);

  logic [XLEN-1:0] w_data;
  logic            w_busy;
  logic [XLEN-1:0] r_data;
  logic            r_busy;

  // Ascending scan lets the highest-indexed write port win a same-address conflict.
  always_comb begin
    w_data = i_regs[i_addr];
    w_busy = i_busy_cur[i_addr];
    if (BYPASS != 0) begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (i_wr_en[k] && (i_wr_addr[k*AW +: AW] == i_addr)) begin
          w_data = i_wr_data[k*XLEN +: XLEN];
        end
      end
      w_busy = i_busy_next[i_addr];
    end
    if (i_addr == '0) begin
      w_data = '0;
      w_busy = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_busy <= 1'b0;
    end else begin
      r_data <= w_data;
      r_busy <= w_busy;
    end
  end

  assign o_data = r_data;
  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: flop array with x0 hardwired to zero,
// NWR write ports, NRD registered read ports and a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NRD*rf_aw(NREGS)-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]            rd_data,
  output logic [NRD-1:0]                 rd_busy,
  input  logic [NWR-1:0]                 wr_en,
  input  logic [NWR*rf_aw(NREGS)-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]            wr_data,
  input  logic                           alloc_en,
  input  logic [rf_aw(NREGS)-1:0]        alloc_addr,
  output logic [NREGS-1:0]               busy_vec
);

  localparam int AW = rf_aw(NREGS);

  logic [NREGS-1:0][XLEN-1:0] r_regs;
  logic [NREGS-1:0][XLEN-1:0] w_regs_next;
  logic [NREGS-1:0]           r_busy;
  logic [NREGS-1:0]           w_busy_next;

  // Writes clear busy first so a same-cycle allocation of the same register wins.
  always_comb begin
    w_regs_next = r_regs;
    w_busy_next = r_busy;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
        w_regs_next[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
        w_busy_next[wr_addr[k*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en && (alloc_addr != '0)) begin
      w_busy_next[alloc_addr] = 1'b1;
    end
    w_regs_next[0] = '0;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      r_regs <= w_regs_next;
      r_busy <= w_busy_next;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    rf_read_port #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NWR    (NWR),
      .BYPASS (BYPASS),
      .AW     (AW)
    ) u_rd (
      .clk         (clk),
      .reset       (reset),
      .i_addr      (rd_addr[p*AW +: AW]),
      .i_regs      (r_regs),
      .i_busy_cur  (r_busy),
      .i_busy_next (w_busy_next),
      .i_wr_en     (wr_en),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .o_data      (rd_data[p*XLEN +: XLEN]),
      .o_busy      (rd_busy[p])
    );
  end

  assign busy_vec = r_busy;

  a_wr_en_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(wr_en));
  a_alloc_en_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(alloc_en));

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp: a bypassing 32x32 dual-write
// instance and a non-bypassing 64x64, 4-read, dual-write instance, both checked
// every cycle against an array-based reference model.
module tb_regfile_mp;

  localparam int NR[2]  = '{32, 64};
  localparam int NRP[2] = '{2, 4};
  localparam int BY[2]  = '{1, 0};

  logic clk;
  logic reset;

  logic [9:0]   d0_rd_addr;
  logic [63:0]  d0_rd_data;
  logic [1:0]   d0_rd_busy;
  logic [1:0]   d0_wr_en;
  logic [9:0]   d0_wr_addr;
  logic [63:0]  d0_wr_data;
  logic         d0_alloc_en;
  logic [4:0]   d0_alloc_addr;
  logic [31:0]  d0_busy_vec;

  logic [23:0]  d1_rd_addr;
  logic [255:0] d1_rd_data;
  logic [3:0]   d1_rd_busy;
  logic [1:0]   d1_wr_en;
  logic [11:0]  d1_wr_addr;
  logic [127:0] d1_wr_data;
  logic         d1_alloc_en;
  logic [5:0]   d1_alloc_addr;
  logic [63:0]  d1_busy_vec;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut0 (
    .clk(clk), .reset(reset),
    .rd_addr(d0_rd_addr), .rd_data(d0_rd_data), .rd_busy(d0_rd_busy),
    .wr_en(d0_wr_en), .wr_addr(d0_wr_addr), .wr_data(d0_wr_data),
    .alloc_en(d0_alloc_en), .alloc_addr(d0_alloc_addr), .busy_vec(d0_busy_vec)
  );

  regfile_mp #(.XLEN(64), .NREGS(64), .NRD(4), .NWR(2), .BYPASS(0)) u_dut1 (
    .clk(clk), .reset(reset),
    .rd_addr(d1_rd_addr), .rd_data(d1_rd_data), .rd_busy(d1_rd_busy),
    .wr_en(d1_wr_en), .wr_addr(d1_wr_addr), .wr_data(d1_wr_data),
    .alloc_en(d1_alloc_en), .alloc_addr(d1_alloc_addr), .busy_vec(d1_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus per instance
  int unsigned s_ra[2][4];
  logic        s_we[2][2];
  int unsigned s_wa[2][2];
  logic [63:0] s_wd[2][2];
  logic        s_al[2];
  int unsigned s_aa[2];

  // reference state and expected outputs
  logic [63:0] m_regs[2][64];
  logic        m_busy[2][64];
  logic [63:0] e_rd[2][4];
  logic        e_rb[2][4];
  logic [63:0] e_bv[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 4; p++) s_ra[c][p] = 0;
      for (int k = 0; k < 2; k++) begin
        s_we[c][k] = 1'b0;
        s_wa[c][k] = 0;
        s_wd[c][k] = '0;
      end
      s_al[c] = 1'b0;
      s_aa[c] = 0;
    end
  endtask

  task automatic drive();
    for (int p = 0; p < 2; p++) d0_rd_addr[p*5 +: 5] = 5'(s_ra[0][p]);
    for (int p = 0; p < 4; p++) d1_rd_addr[p*6 +: 6] = 6'(s_ra[1][p]);
    for (int k = 0; k < 2; k++) begin
      d0_wr_en[k]           = s_we[0][k];
      d0_wr_addr[k*5 +: 5]  = 5'(s_wa[0][k]);
      d0_wr_data[k*32 +: 32] = s_wd[0][k][31:0];
      d1_wr_en[k]           = s_we[1][k];
      d1_wr_addr[k*6 +: 6]  = 6'(s_wa[1][k]);
      d1_wr_data[k*64 +: 64] = s_wd[1][k];
    end
    d0_alloc_en   = s_al[0];
    d0_alloc_addr = 5'(s_aa[0]);
    d1_alloc_en   = s_al[1];
    d1_alloc_addr = 6'(s_aa[1]);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 64; r++) begin
        m_regs[c][r] = '0;
        m_busy[c][r] = 1'b0;
      end
      for (int p = 0; p < 4; p++) begin
        e_rd[c][p] = '0;
        e_rb[c][p] = 1'b0;
      end
      e_bv[c] = '0;
    end
  endtask

  // Expected outputs for the stimulus currently applied, then commit the edge.
  task automatic model_step(input int c);
    int unsigned a;
    logic        hit;
    logic [63:0] hv;
    logic        post;
    for (int p = 0; p < NRP[c]; p++) begin
      a   = s_ra[c][p];
      hit = 1'b0;
      hv  = '0;
      for (int k = 0; k < 2; k++) begin
        if (s_we[c][k] && s_wa[c][k] == a) begin
          hit = 1'b1;
          hv  = s_wd[c][k];
        end
      end
      post = hit ? 1'b0 : m_busy[c][a];
      if (s_al[c] && s_aa[c] == a) post = 1'b1;
      if (a == 0) begin
        e_rd[c][p] = '0;
        e_rb[c][p] = 1'b0;
      end else if (BY[c] != 0) begin
        e_rd[c][p] = hit ? hv : m_regs[c][a];
        e_rb[c][p] = post;
      end else begin
        e_rd[c][p] = m_regs[c][a];
        e_rb[c][p] = m_busy[c][a];
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (s_we[c][k] && s_wa[c][k] != 0) begin
        m_regs[c][s_wa[c][k]] = s_wd[c][k];
        m_busy[c][s_wa[c][k]] = 1'b0;
      end
    end
    if (s_al[c] && s_aa[c] != 0) m_busy[c][s_aa[c]] = 1'b1;
    e_bv[c] = '0;
    for (int r = 0; r < NR[c]; r++) e_bv[c][r] = m_busy[c][r];
  endtask

  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("d0_rd_data%0d", p), 64'(d0_rd_data[p*32 +: 32]), e_rd[0][p]);
      chk($sformatf("d0_rd_busy%0d", p), 64'(d0_rd_busy[p]), 64'(e_rb[0][p]));
    end
    chk("d0_busy_vec", 64'(d0_busy_vec), e_bv[0]);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("d1_rd_data%0d", p), d1_rd_data[p*64 +: 64], e_rd[1][p]);
      chk($sformatf("d1_rd_busy%0d", p), 64'(d1_rd_busy[p]), 64'(e_rb[1][p]));
    end
    chk("d1_busy_vec", d1_busy_vec, e_bv[1]);
  endtask

  // Called at a falling edge: apply stimulus, step model, check after the edge.
  task automatic cycle();
    drive();
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  function automatic int unsigned rnd_addr(input int c);
    if ($urandom_range(0, 1) == 1) return $urandom_range(0, 3);
    return $urandom_range(0, NR[c] - 1);
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    drive();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_d0_rd_data", d0_rd_data, 64'h0);
    chk("rst_d0_busy_vec", 64'(d0_busy_vec), 64'h0);
    chk("rst_d1_rd_data0", d1_rd_data[63:0], 64'h0);
    chk("rst_d1_busy_vec", d1_busy_vec, 64'h0);
    reset = 1'b0;

    // x0 write dropped, reads of x0 are zero and never busy
    idle();
    s_we[0][0] = 1'b1; s_wa[0][0] = 0; s_wd[0][0] = 64'h1234;
    s_we[1][0] = 1'b1; s_wa[1][0] = 0; s_wd[1][0] = 64'h1234;
    s_al[0] = 1'b1; s_aa[0] = 0;
    cycle();
    idle();
    cycle();
    chk("x0_rd0", 64'(d0_rd_data[31:0]), 64'h0);
    chk("x0_rd1", 64'(d0_rd_data[63:32]), 64'h0);
    chk("x0_busy", 64'(d0_rd_busy), 64'h0);
    chk("x0_busy_vec", 64'(d0_busy_vec), 64'h0);

    // same-cycle write/read of x7
    idle();
    s_we[0][0] = 1'b1; s_wa[0][0] = 7; s_wd[0][0] = 64'hA5A5A5A5;
    s_we[1][0] = 1'b1; s_wa[1][0] = 7; s_wd[1][0] = 64'hA5A5A5A5;
    s_ra[0][0] = 7; s_ra[1][0] = 7;
    cycle();
    chk("byp_on", 64'(d0_rd_data[31:0]), 64'hA5A5A5A5);
    chk("byp_off", d1_rd_data[63:0], 64'h0);
    idle();
    s_ra[0][0] = 7; s_ra[1][0] = 7;
    cycle();
    chk("byp_off_later", d1_rd_data[63:0], 64'hA5A5A5A5);

    // dual write to x3, higher port wins (also through bypass)
    idle();
    s_we[0][0] = 1'b1; s_wa[0][0] = 3; s_wd[0][0] = 64'h11;
    s_we[0][1] = 1'b1; s_wa[0][1] = 3; s_wd[0][1] = 64'h22;
    s_ra[0][1] = 3;
    cycle();
    chk("dual_byp", 64'(d0_rd_data[63:32]), 64'h22);
    idle();
    s_ra[0][0] = 3;
    cycle();
    chk("dual_rd", 64'(d0_rd_data[31:0]), 64'h22);

    // scoreboard on x9
    idle();
    s_al[0] = 1'b1; s_aa[0] = 9; s_al[1] = 1'b1; s_aa[1] = 9;
    cycle();
    chk("sb_alloc", 64'(d0_busy_vec[9]), 64'h1);
    idle();
    s_ra[0][0] = 9; s_ra[1][0] = 9;
    cycle();
    chk("sb_rd_busy", 64'(d0_rd_busy[0]), 64'h1);
    idle();
    s_we[0][0] = 1'b1; s_wa[0][0] = 9; s_wd[0][0] = 64'h99;
    s_we[1][0] = 1'b1; s_wa[1][0] = 9; s_wd[1][0] = 64'h99;
    s_al[0] = 1'b1; s_aa[0] = 9; s_al[1] = 1'b1; s_aa[1] = 9;
    cycle();
    chk("sb_wr_alloc", 64'(d0_busy_vec[9]), 64'h1);
    idle();
    s_we[0][0] = 1'b1; s_wa[0][0] = 9; s_wd[0][0] = 64'h9A;
    s_we[1][0] = 1'b1; s_wa[1][0] = 9; s_wd[1][0] = 64'h9A;
    s_ra[0][0] = 9; s_ra[1][0] = 9;
    cycle();
    chk("sb_clear", 64'(d0_busy_vec[9]), 64'h0);
    chk("sb_rd_post", 64'(d0_rd_busy[0]), 64'h0);
    chk("sb_rd_pre", 64'(d1_rd_busy[0]), 64'h1);
    chk("sb_clear_d1", 64'(d1_busy_vec[9]), 64'h0);

    // reset asserted between edges discards state immediately
    idle();
    s_al[0] = 1'b1; s_aa[0] = 11; s_al[1] = 1'b1; s_aa[1] = 11;
    cycle();
    idle();
    s_we[0][0] = 1'b1; s_wa[0][0] = 5; s_wd[0][0] = 64'hDEADBEEF;
    s_we[1][0] = 1'b1; s_wa[1][0] = 5; s_wd[1][0] = 64'hDEADBEEF;
    cycle();
    idle();
    s_ra[0][0] = 5; s_ra[0][1] = 5; s_ra[1][0] = 5;
    cycle();
    chk("rmid_pre", 64'(d0_rd_data[31:0]), 64'hDEADBEEF);
    idle();
    drive();
    #2 reset = 1'b1;
    #1;
    chk("rmid_rd0", 64'(d0_rd_data[31:0]), 64'h0);
    chk("rmid_rd1", 64'(d0_rd_data[63:32]), 64'h0);
    chk("rmid_bv", 64'(d0_busy_vec), 64'h0);
    chk("rmid_d1_rd0", d1_rd_data[63:0], 64'h0);
    chk("rmid_d1_bv", d1_busy_vec, 64'h0);
    #1 reset = 1'b0;
    model_reset();
    idle();
    s_ra[0][0] = 5; s_ra[1][0] = 5;
    cycle();
    chk("rmid_post", 64'(d0_rd_data[31:0]), 64'h0);
    chk("rmid_post_d1", d1_rd_data[63:0], 64'h0);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      for (int c = 0; c < 2; c++) begin
        for (int p = 0; p < 4; p++) s_ra[c][p] = rnd_addr(c);
        for (int k = 0; k < 2; k++) begin
          s_we[c][k] = 1'($urandom_range(0, 1));
          s_wa[c][k] = rnd_addr(c);
          s_wd[c][k] = (c == 0) ? {32'h0, $urandom} : {$urandom, $urandom};
        end
        s_al[c] = ($urandom_range(0, 3) == 0);
        s_aa[c] = rnd_addr(c);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
